// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } uart_state_t;

    function automatic int cycles_per_symbol(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through synchronous FIFO for received bytes.
// A push into a full FIFO succeeds only when a pop frees the slot that same cycle.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = UART_DATA_BITS,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx_fifo: DEPTH must be a power of two >= 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign empty = (level == '0);
    assign full  = (level == (AW+1)'(DEPTH));
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && !rd_en) begin
                level <= level + 1'b1;
            end else if (rd_en && !wr_en) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver with mid-bit sampling and an FWFT receive FIFO.
// Define UART_RX_PARITY_EN for an even-parity bit and the parity_err_o port.
module uart_rx
    import uart_pkg::*;
#(
    parameter int FREQ  = 50000000,
    parameter int BAUD  = 115200,
    parameter int DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] data_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [$clog2(DEPTH):0]    level_o,
    output logic                      frame_err_o,
    output logic                      overflow_o
`ifdef UART_RX_PARITY_EN
    ,
    output logic                      parity_err_o
`endif
);

    localparam int CPS = cycles_per_symbol(FREQ, BAUD);
    localparam int CW  = (CPS < 4) ? 2 : $clog2(CPS);
    localparam int IW  = $clog2(UART_DATA_BITS);

    localparam logic [CW-1:0] LAST     = CW'(CPS - 1);
    localparam logic [CW-1:0] HALF     = CW'(CPS / 2 - 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(UART_DATA_BITS - 1);

    if (CPS < 4) begin : g_bad_cps
        $error("uart_rx: FREQ/BAUD must be at least 4");
    end

    uart_state_t               state;
    logic                      sync1;
    logic                      rxs;
    logic [CW-1:0]             cnt;
    logic [IW-1:0]             idx;
    logic [UART_DATA_BITS-1:0] sh;
    logic                      sample;
    logic                      stop_ok;
    logic                      push;
    logic                      pop;
    logic                      empty;
    logic                      full;
    logic [UART_DATA_BITS-1:0] dout;

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    assign stop_ok = ~^{sh, par_bit};
`else
    assign stop_ok = 1'b1;
`endif

    assign sample  = (cnt == LAST);
    assign push    = (state == STOP) && sample && rxs && stop_ok;
    assign valid_o = !empty;
    assign pop     = valid_o && ready_i;
    assign data_o  = valid_o ? dout : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1       <= 1'b1;
            rxs         <= 1'b1;
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            sh          <= '0;
            frame_err_o <= 1'b0;
            overflow_o  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit      <= 1'b0;
            parity_err_o <= 1'b0;
`endif
        end else begin
            sync1       <= rx;
            rxs         <= sync1;
            frame_err_o <= 1'b0;
            overflow_o  <= push && full && !pop;
`ifdef UART_RX_PARITY_EN
            parity_err_o <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (!rxs) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= rxs ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (sample) begin
                        cnt <= '0;
                        sh  <= {rxs, sh[UART_DATA_BITS-1:1]};
                        idx <= idx + 1'b1;
                        if (idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARITY: begin
`ifdef UART_RX_PARITY_EN
                    if (sample) begin
                        cnt     <= '0;
                        par_bit <= rxs;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`else
                    state <= IDLE;
`endif
                end
                STOP: begin
                    if (sample) begin
                        cnt <= '0;
                        // Low stop bit wins over parity and blocks re-arm until idle.
                        if (rxs) begin
                            state <= IDLE;
`ifdef UART_RX_PARITY_EN
                            parity_err_o <= !stop_ok;
`endif
                        end else begin
                            frame_err_o <= 1'b1;
                            state       <= WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (rxs) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    uart_rx_fifo #(
        .WIDTH(UART_DATA_BITS),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .din  (sh),
        .pop  (pop),
        .dout (dout),
        .empty(empty),
        .full (full),
        .level(level_o)
    );

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table, corner sequences, random frames.
module tb_uart_rx;

    localparam int FREQ  = 1600;
    localparam int BAUD  = 100;
    localparam int DEPTH = 16;
    localparam int CPS   = FREQ / BAUD;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    // Start drive edge to stop-bit mid-sample edge: 2 sync + 1 detect + half + frame bits.
    localparam int LAT = 3 + CPS / 2 + (9 + (PAR_EN ? 1 : 0)) * CPS;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic [4:0] level_o;
    logic       frame_err_o;
    logic       overflow_o;
`ifdef UART_RX_PARITY_EN
    logic       parity_err_o;
`endif

    uart_rx #(
        .FREQ (FREQ),
        .BAUD (BAUD),
        .DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .level_o    (level_o),
        .frame_err_o(frame_err_o),
        .overflow_o (overflow_o)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err_o(parity_err_o)
`endif
    );

    initial forever #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       badpar;
        int         gap;
        int         exp_n;
        int         exp_ferr;
        int         exp_perr;
    } vec_t;

    int         checks;
    int         failures;
    int         cyc;
    int         n_ferr;
    int         n_ovf;
    int         n_perr;
    int         vhigh;
    int         rise_cyc;
    int         ovf_cyc;
    int         frame_start;
    logic       vprev;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    vec_t       vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (valid_o && ready_i) got.push_back(data_o);
                if (valid_o) vhigh++;
                if (valid_o && !vprev) rise_cyc = cyc;
                vprev = valid_o;
                if (frame_err_o) n_ferr++;
                if (overflow_o) begin
                    n_ovf++;
                    ovf_cyc = cyc;
                end
`ifdef UART_RX_PARITY_EN
                if (parity_err_o) n_perr++;
`endif
                if (!valid_o) chk("data_zero", {24'd0, data_o}, 32'd0);
                if (frame_err_o || overflow_o)
                    chk("pulse_excl", {31'd0, frame_err_o & overflow_o}, 32'd0);
            end
        end
    endtask

    task automatic clr();
        got.delete();
        exp_q.delete();
        n_ferr   = 0;
        n_ovf    = 0;
        n_perr   = 0;
        vhigh    = 0;
        rise_cyc = -1;
        ovf_cyc  = -1;
    endtask

    task automatic expect_q(input string name);
        chk({name, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk(name, {24'd0, got[i]}, {24'd0, exp_q[i]});
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPS) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic badpar);
        frame_start = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        if (PAR_EN) drive_bit((^b) ^ badpar);
        drive_bit(stop);
    endtask

    function automatic vec_t mk(input logic [7:0] d, input logic s, input logic bp,
                                input int g, input int n, input int fe, input int pe);
        vec_t v;
        v.data = d; v.stop = s; v.badpar = bp; v.gap = g;
        v.exp_n = n; v.exp_ferr = fe; v.exp_perr = pe;
        return v;
    endfunction

    initial begin
        logic       busy;
        logic [7:0] b;
        logic       s;
        logic       bp;
        int         ef;
        int         ep;

        checks = 0; failures = 0; cyc = 0; vprev = 1'b0;
        clr();
        vecs.push_back(mk(8'h55, 1'b1, 1'b0, 4, 1, 0, 0));
        vecs.push_back(mk(8'h00, 1'b1, 1'b0, 0, 1, 0, 0));
        vecs.push_back(mk(8'hFF, 1'b1, 1'b0, 4, 1, 0, 0));
        vecs.push_back(mk(8'hA5, 1'b0, 1'b0, 8, 0, 1, 0));
        vecs.push_back(mk(8'h3C, 1'b1, 1'b0, 2, 1, 0, 0));
        vecs.push_back(mk(8'h80, 1'b1, 1'b0, 0, 1, 0, 0));
        vecs.push_back(mk(8'h01, 1'b0, 1'b0, 6, 0, 1, 0));
        vecs.push_back(mk(8'h7E, 1'b1, 1'b0, 3, 1, 0, 0));
`ifdef UART_RX_PARITY_EN
        vecs.push_back(mk(8'h07, 1'b1, 1'b1, 4, 0, 0, 1));
        vecs.push_back(mk(8'h07, 1'b0, 1'b1, 6, 0, 1, 0));
        vecs.push_back(mk(8'h07, 1'b1, 1'b0, 4, 1, 0, 0));
`endif

        fork
            monitor();
            forever begin
                @(posedge clk);
                cyc++;
            end
        join_none

        rst = 1'b1; rx = 1'b1; ready_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_level", {27'd0, level_o}, 32'd0);
        chk("rst_data", {24'd0, data_o}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err_o}, 32'd0);
        chk("rst_ovf", {31'd0, overflow_o}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(5);

        // Test 1: single frame, latency and one-cycle FWFT handoff
        ready_i = 1'b1;
        clr();
        send_frame(8'h55, 1'b1, 1'b0);
        idle(4);
        exp_q.push_back(8'h55);
        expect_q("t1_data");
        chk("t1_latency", rise_cyc, frame_start + LAT);
        chk("t1_vhigh", vhigh, 1);
        chk("t1_level", {27'd0, level_o}, 32'd0);

        // Test 2: start glitch then a real frame
        clr();
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        idle(2 * CPS);
        chk("t2_glitch_n", got.size(), 0);
        chk("t2_glitch_ferr", n_ferr, 0);
        send_frame(8'hC3, 1'b1, 1'b0);
        idle(4);
        exp_q.push_back(8'hC3);
        expect_q("t2_data");
        chk("t2_ferr", n_ferr, 0);

        // Test 3: framing error, stuck-low line, recovery
        clr();
        send_frame(8'hA5, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        idle(4);
        send_frame(8'h3C, 1'b1, 1'b0);
        idle(4);
        exp_q.push_back(8'h3C);
        expect_q("t3_data");
        chk("t3_ferr", n_ferr, 1);

        // Vector table
        foreach (vecs[k]) begin
            clr();
            send_frame(vecs[k].data, vecs[k].stop, vecs[k].badpar);
            idle(vecs[k].gap);
            chk("vec_n", got.size(), vecs[k].exp_n);
            if (vecs[k].exp_n == 1 && got.size() > 0)
                chk("vec_data", {24'd0, got[0]}, {24'd0, vecs[k].data});
            chk("vec_ferr", n_ferr, vecs[k].exp_ferr);
`ifdef UART_RX_PARITY_EN
            chk("vec_perr", n_perr, vecs[k].exp_perr);
`endif
        end
        idle(4);

        // Test 4: fill past full with consumer stalled
        ready_i = 1'b0;
        clr();
        for (int i = 0; i <= DEPTH; i++) begin
            send_frame(8'(i), 1'b1, 1'b0);
            if (i == DEPTH - 1) begin
                chk("t4_full_level", {27'd0, level_o}, DEPTH);
                chk("t4_no_ovf_yet", n_ovf, 0);
            end
        end
        chk("t4_level", {27'd0, level_o}, DEPTH);
        chk("t4_ovf", n_ovf, 1);
        chk("t4_ovf_time", ovf_cyc, frame_start + LAT);
        ready_i = 1'b1;
        idle(DEPTH + 4);
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(8'(i));
        expect_q("t4_drain");
        chk("t4_empty", {27'd0, level_o}, 32'd0);

        // Test 6: push and pop together while full
        ready_i = 1'b0;
        clr();
        for (int i = 0; i < DEPTH; i++) send_frame(8'hA0 + 8'(i), 1'b1, 1'b0);
        chk("t6_full", {27'd0, level_o}, DEPTH);
        fork
            send_frame(8'h5A, 1'b1, 1'b0);
            begin
                repeat (LAT - 1) @(posedge clk);
                #1 ready_i = 1'b1;
                @(posedge clk);
                #1 ready_i = 1'b0;
                @(negedge clk);
                chk("t6_level", {27'd0, level_o}, DEPTH);
                chk("t6_head", {24'd0, data_o}, 32'hA1);
                chk("t6_ovf_now", {31'd0, overflow_o}, 32'd0);
            end
        join
        ready_i = 1'b1;
        idle(DEPTH + 4);
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(8'hA0 + 8'(i));
        exp_q.push_back(8'h5A);
        expect_q("t6_drain");
        chk("t6_ovf", n_ovf, 0);

        // Test 5: reset in the middle of data bit 3
        ready_i = 1'b0;
        clr();
        send_frame(8'h11, 1'b1, 1'b0);
        chk("t5_pre_level", {27'd0, level_o}, 32'd1);
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        rx = 1'b1;
        repeat (CPS / 2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_valid", {31'd0, valid_o}, 32'd0);
        chk("t5_level", {27'd0, level_o}, 32'd0);
        chk("t5_data", {24'd0, data_o}, 32'd0);
        chk("t5_ferr", {31'd0, frame_err_o}, 32'd0);
        chk("t5_ovf", {31'd0, overflow_o}, 32'd0);
        idle(6 * CPS);
        ready_i = 1'b1;
        clr();
        send_frame(8'h81, 1'b1, 1'b0);
        idle(4);
        exp_q.push_back(8'h81);
        expect_q("t5_data");
        chk("t5_ferr_cnt", n_ferr, 0);

        // Random frames against a queue model, consumer randomly stalled
        clr();
        ef = 0; ep = 0;
        busy = 1'b1;
        fork
            begin
                for (int n = 0; n < 30; n++) begin
                    b  = 8'($urandom);
                    s  = ($urandom_range(0, 7) != 0);
                    bp = PAR_EN ? ($urandom_range(0, 3) == 0) : 1'b0;
                    if (s && !bp) exp_q.push_back(b);
                    if (!s) ef++;
                    else if (bp) ep++;
                    send_frame(b, s, bp);
                    idle(s ? $urandom_range(0, 12) : $urandom_range(4, 12));
                end
                busy = 1'b0;
            end
            while (busy) begin
                @(posedge clk);
                #1 ready_i = 1'($urandom_range(0, 1));
            end
        join
        ready_i = 1'b1;
        idle(DEPTH + 8);
        expect_q("rand_data");
        chk("rand_ferr", n_ferr, ef);
        chk("rand_ovf", n_ovf, 0);
`ifdef UART_RX_PARITY_EN
        chk("rand_perr", n_perr, ep);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Synthesizable UART receiver with a receive FIFO.
- Consumes the serial line driven by the simulation UART host model's tx output, or by a real pin.
- Recovers 8N1 frames using mid-bit sampling.
- Delivers bytes to the core through a first-word-fall-through valid/ready interface, with framing-error and overflow reporting.

Parameters:
- FREQ, 50000000, clock frequency in Hz.
- BAUD, 115200, line rate in symbols/s.
- DEPTH, 16, FIFO entries; power of two, ≥2.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  reset; synchronous, active-high.
- rx  input  1  asynchronous serial line, idle high.
- data_o  output  8  head byte of FIFO.
- valid_o  output  1  FIFO non-empty.
- ready_i  input  1  consumer accepts head byte.
- level_o  output  $clog2(DEPTH)+1  FIFO occupancy.
- frame_err_o  output  1  one-cycle pulse, stop bit sampled low.
- overflow_o  output  1  one-cycle pulse, byte dropped because FIFO full.

Behaviour:
- CPS = FREQ/BAUD (integer divide); elaboration error if CPS < 4.
- Input synchronizer: rx passes through a 2-FF synchronizer (both FFs reset to 1) before use. All decisions use the synchronized value rxs.
- Reset values: valid_o=0, level_o=0, frame_err_o=0, overflow_o=0, data_o=8'h00. FSM returns to IDLE; counters, shift register and FIFO pointers clear. Reset mid-frame abandons the partial byte with no pulses.
- data_o is forced to 0 whenever valid_o=0.
- IDLE: when rxs==0 → START; cycle counter cnt=0.
- START: cnt increments each cycle. At cnt==CPS/2-1, sample rxs:
  - if 1 → glitch; go to IDLE with no report;
  - else → DATA; cnt=0, bit index=0.
- DATA: at cnt==CPS-1, shift rxs into the shift register LSB-first and set cnt=0. After bit index 7 → STOP.
- STOP: at cnt==CPS-1, sample rxs:
  - if 1 → push byte to FIFO; go to IDLE;
  - if 0 → pulse frame_err_o, discard byte, go to WAIT_HIGH.
- WAIT_HIGH: stay until rxs==1, then go to IDLE. Prevents a break condition or stuck-low line from producing repeated frames.
- Re-arm at the stop-bit mid-sample lets back-to-back frames with exactly one stop bit be received.
- Latency: a pushed byte is visible on valid_o/data_o the cycle after the stop-bit sample.
- FIFO:
  - pop when valid_o && ready_i;
  - push and pop in the same cycle is allowed at any occupancy, including full, and level_o is unchanged;
  - push while full without a pop → byte dropped, overflow_o pulses, FIFO contents untouched;
  - pointers wrap modulo DEPTH;
  - level_o reaches DEPTH exactly when full.
- frame_err_o and overflow_o never assert in the same cycle. Only a completed stop bit can push, and a frame-error frame never pushes.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- When defined:
  - an even-parity bit follows data bit 7 and is sampled in an added PARITY state at cnt==CPS-1;
  - extra port parity_err_o (output, 1 bit, reset 0) pulses for one cycle at the stop-bit sample when parity mismatched;
  - the byte is discarded and the FSM returns to IDLE normally (or WAIT_HIGH if the stop bit is also low; frame_err_o has priority and parity_err_o is then suppressed).
- When undefined: no PARITY state, no parity_err_o port; 8N1 only.

Decomposition:
- Package uart_pkg holds:
  - the FSM state enum typedef (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH);
  - constant UART_DATA_BITS=8;
  - function cycles_per_symbol(freq, baud).
- One sub-module, uart_rx_fifo: FWFT synchronous FIFO with params WIDTH, DEPTH and ports push/din/pop/dout/empty/full/level.

Test Plan:
1. FREQ=1600, BAUD=100 (CPS=16); drive 0x55 8N1 with ready_i=1 → valid_o high for 1 cycle with data_o=0x55, exactly 1 cycle after the stop-bit mid-sample; level_o returns to 0.
2. rx low for 3 cycles then high → no push, no pulses; a following 0xC3 frame is received correctly.
3. 0xA5 frame with stop bit 0, line held low 40 cycles, then 0x3C frame → frame_err_o single pulse, 0xA5 absent, 0x3C delivered.
4. ready_i=0, send DEPTH+1 bytes 0x00..0x10 → level_o=DEPTH, one overflow_o pulse on the last byte; draining yields 0x00..0x0F in order.
5. rst asserted for 1 cycle during data bit 3 of 0xFF, then frame 0x81 → no output from the aborted frame; 0x81 delivered; all outputs 0 in the cycle after rst.
6. FIFO full, ready_i=1 on the push cycle of a new byte → no overflow_o, level_o stays DEPTH, head advances; with UART_RX_PARITY_EN, a bad-parity 0x07 → parity_err_o pulse and no push.
